sig_frame_accum: RTL and testbench



---
 rtl/sig_pkg.sv | 44 ++++
 rtl/sig_sat_shift.sv | 28 ++
 rtl/sig_frame_accum.sv | 137 +++++++++++++
 tb/tb_sig_frame_accum.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// Shared types and helpers for the signed datapath stages:
// frame FSM states, a constant clog2 and a generic saturate-to-width function.
package sig_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] value;
  } sat_res_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Clamp a sign-extended value into the signed range of a dw-bit word.
  function automatic sat_res_t sat_trunc(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_res_t           r;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      r.sat   = 1'b1;
      r.value = hi;
    end else if (v < lo) begin
      r.sat   = 1'b1;
      r.value = lo;
    end else begin
      r.sat   = 1'b0;
      r.value = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/sig_sat_shift.sv
// Combinational arithmetic right shift of a wide signed sum followed by
// saturation back to DW bits.
module sig_sat_shift
  import sig_pkg::*;
#(
  parameter int DW    = 16,
  parameter int ACC_W = 24,
  parameter int SHIFT = 3
) (
  input  logic signed [ACC_W-1:0] sum_i,
  output logic signed [DW-1:0]    data_o,
  output logic                    sat_o
);

  logic signed [ACC_W-1:0] sh_s;
  logic signed [63:0]      sh64_s;
  sat_res_t                res_s;

  // Floor-scale the sum, widen it and clamp into the output range.
  always_comb begin
    sh_s   = sum_i >>> SHIFT;
    sh64_s = {{(64 - ACC_W){sh_s[ACC_W-1]}}, sh_s};
    res_s  = sat_trunc(sh64_s, DW);
    data_o = DW'(res_s.value);
    sat_o  = res_s.sat;
  end

endmodule

// File: rtl/sig_frame_accum.sv
// Frame accumulator: sums N signed samples, scales/saturates the total and
// holds it on a valid/ready output; one bubble cycle per frame.
module sig_frame_accum
  import sig_pkg::*;
#(
  parameter int DW    = 16,
  parameter int N     = 8,
  parameter int SHIFT = 3,
  parameter int ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic signed [DW-1:0]     in_data,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic signed [DW-1:0]     out_data,
  output logic                     out_sat,
  output logic [clog2(N+1)-1:0]    frm_cnt
);

  localparam int CW = clog2(N + 1);

  if (ACC_W < DW + clog2(N)) begin : g_acc_w_chk
    $error("sig_frame_accum: ACC_W too narrow for DW and N");
  end
  if (ACC_W > 64) begin : g_acc_w_max_chk
    $error("sig_frame_accum: ACC_W above 64 not supported");
  end
  if (N < 2 || N > 256) begin : g_n_chk
    $error("sig_frame_accum: N outside 2..256");
  end
  if (SHIFT < 0 || SHIFT >= ACC_W) begin : g_shift_chk
    $error("sig_frame_accum: SHIFT outside 0..ACC_W-1");
  end

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    in_rdy_q, in_rdy_d;
  logic                    out_vld_q, out_vld_d;
  logic signed [DW-1:0]    out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [ACC_W-1:0] sum_s;
  logic signed [DW-1:0]    sh_data_s;
  logic                    sh_sat_s;

  assign sum_s = acc_q + {{(ACC_W - DW){in_data[DW-1]}}, in_data};

  sig_sat_shift #(
    .DW    (DW),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_sat_shift (
    .sum_i  (sum_s),
    .data_o (sh_data_s),
    .sat_o  (sh_sat_s)
  );

  // Next-state logic for the frame FSM, accumulator, counter and outputs.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    in_rdy_d   = in_rdy_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ACC: begin
        if (in_vld && in_rdy_q) begin
          if (cnt_q == CW'(N - 1)) begin
            acc_d      = '0;
            cnt_d      = '0;
            out_data_d = sh_data_s;
            out_sat_d  = sh_sat_s;
            out_vld_d  = 1'b1;
            in_rdy_d   = 1'b0;
            state_d    = HOLD;
          end else begin
            acc_d = sum_s;
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ACC;
        end
      end
      HOLD: begin
        // Input stays blocked on the release edge: that is the frame bubble.
        if (out_rdy) begin
          out_vld_d = 1'b0;
          in_rdy_d  = 1'b1;
          state_d   = ACC;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        acc_d     = '0;
        cnt_d     = '0;
        out_vld_d = 1'b0;
        in_rdy_d  = 1'b1;
        state_d   = ACC;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      in_rdy_q   <= 1'b1;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      in_rdy_q   <= in_rdy_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign in_rdy   = in_rdy_q;
  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;
  assign frm_cnt  = cnt_q;

endmodule

// File: tb/tb_sig_frame_accum.sv
// Self-checking bench: two instances (SHIFT=0 and SHIFT=2) share one stimulus
// stream; table vectors, hand sequences and random frames against a model.
module tb_sig_frame_accum;

  localparam int DW    = 8;
  localparam int N     = 4;
  localparam int ACC_W = 11;

  logic              clk;
  logic              rst;
  logic              in_vld;
  logic signed [7:0] in_data;
  logic              out_rdy;

  logic              in_rdy0, out_vld0, out_sat0;
  logic signed [7:0] out_data0;
  logic [2:0]        frm_cnt0;
  logic              in_rdy2, out_vld2, out_sat2;
  logic signed [7:0] out_data2;
  logic [2:0]        frm_cnt2;

  int total;
  int bad;

  sig_frame_accum #(.DW(DW), .N(N), .SHIFT(0), .ACC_W(ACC_W)) u_s0 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy0), .in_data(in_data),
    .out_vld(out_vld0), .out_rdy(out_rdy), .out_data(out_data0), .out_sat(out_sat0),
    .frm_cnt(frm_cnt0)
  );

  sig_frame_accum #(.DW(DW), .N(N), .SHIFT(2), .ACC_W(ACC_W)) u_s2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy2), .in_data(in_data),
    .out_vld(out_vld2), .out_rdy(out_rdy), .out_data(out_data2), .out_sat(out_sat2),
    .frm_cnt(frm_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int s[4];
    int e0;
    int t0;
    int e2;
    int t2;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Floor division by 2^sh, then clamp to the signed 8-bit range.
  function automatic int ref_scale(input int sum, input int sh, output int sat);
    int d;
    int q;
    d = 1 << sh;
    if (sum >= 0) q = sum / d;
    else q = -((-sum + d - 1) / d);
    sat = 0;
    if (q > 127) begin q = 127; sat = 1; end
    if (q < -128) begin q = -128; sat = 1; end
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int exp_cnt);
    int t;
    in_vld  = 1'b1;
    in_data = d[7:0];
    t = 0;
    while (!in_rdy0 && t < 50) begin
      step();
      t = t + 1;
    end
    if (t >= 50) chk("push_timeout", t, 0);
    step();
    chk("frm_cnt0", frm_cnt0, exp_cnt);
    chk("frm_cnt2", frm_cnt2, exp_cnt);
  endtask

  task automatic run_frame(input int s[4], input int gap_max, input int rdy_delay,
                           input int e0, input int t0, input int e2, input int t2);
    int g;
    for (int i = 0; i < 4; i++) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      in_vld = 1'b0;
      for (int k = 0; k < g; k++) begin
        step();
        chk("frm_cnt_gap", frm_cnt0, i);
      end
      push(s[i], (i == 3) ? 0 : i + 1);
    end
    in_vld = 1'b0;
    if (rdy_delay > 0) out_rdy = 1'b0;
    chk("out_vld0", out_vld0, 1);
    chk("out_vld2", out_vld2, 1);
    chk("in_rdy_hold", in_rdy0, 0);
    chk("out_data0", out_data0, e0);
    chk("out_sat0", out_sat0, t0);
    chk("out_data2", out_data2, e2);
    chk("out_sat2", out_sat2, t2);
    for (int k = 0; k < rdy_delay; k++) begin
      in_vld  = 1'b1;
      in_data = 8'sd99;
      step();
      chk("bp_vld", out_vld0, 1);
      chk("bp_rdy", in_rdy0, 0);
      chk("bp_data0", out_data0, e0);
      chk("bp_sat0", out_sat0, t0);
      chk("bp_data2", out_data2, e2);
      chk("bp_cnt", frm_cnt0, 0);
    end
    out_rdy = 1'b1;
    step();
    in_vld = 1'b0;
    chk("release_vld", out_vld0, 0);
    chk("release_rdy", in_rdy0, 1);
    chk("release_cnt", frm_cnt0, 0);
  endtask

  initial begin
    int s[4];
    int sum;
    int e0, t0, e2, t2;

    total = 0;
    bad   = 0;

    tbl[0].s = '{10, 20, -5, 7};       tbl[0].e0 = 32;   tbl[0].t0 = 0; tbl[0].e2 = 8;    tbl[0].t2 = 0;
    tbl[1].s = '{127, 127, 127, 127};  tbl[1].e0 = 127;  tbl[1].t0 = 1; tbl[1].e2 = 127;  tbl[1].t2 = 0;
    tbl[2].s = '{-128, -128, -128, -128}; tbl[2].e0 = -128; tbl[2].t0 = 1; tbl[2].e2 = -128; tbl[2].t2 = 0;
    tbl[3].s = '{100, 100, 100, 101};  tbl[3].e0 = 127;  tbl[3].t0 = 1; tbl[3].e2 = 100;  tbl[3].t2 = 0;
    tbl[4].s = '{-3, -3, -3, -3};      tbl[4].e0 = -12;  tbl[4].t0 = 0; tbl[4].e2 = -3;   tbl[4].t2 = 0;
    tbl[5].s = '{-1, 0, 0, 0};         tbl[5].e0 = -1;   tbl[5].t0 = 0; tbl[5].e2 = -1;   tbl[5].t2 = 0;

    rst     = 1'b1;
    in_vld  = 1'b0;
    in_data = 8'sd0;
    out_rdy = 1'b1;
    step();
    step();
    chk("rst_out_vld", out_vld0, 0);
    chk("rst_out_data", out_data0, 0);
    chk("rst_out_sat", out_sat0, 0);
    chk("rst_frm_cnt", frm_cnt0, 0);
    chk("rst_in_rdy", in_rdy0, 1);
    chk("rst_out_vld2", out_vld2, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_frame(tbl[v].s, 0, 0, tbl[v].e0, tbl[v].t0, tbl[v].e2, tbl[v].t2);
    end

    // Backpressure with in_vld asserted during HOLD, then a clean next frame.
    s = '{1, 2, 3, 4};
    run_frame(s, 0, 5, 10, 0, 2, 0);
    run_frame(tbl[0].s, 0, 0, 32, 0, 8, 0);

    // Reset in the middle of a frame discards the partial sum.
    push(50, 1);
    push(50, 2);
    in_vld = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_cnt", frm_cnt0, 0);
    chk("midrst_rdy", in_rdy0, 1);
    run_frame(s, 0, 0, 10, 0, 2, 0);

    // Reset while a result is pending in HOLD.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(tbl[3].s[i], (i == 3) ? 0 : i + 1);
    in_vld = 1'b0;
    chk("hold_vld", out_vld0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("holdrst_vld", out_vld0, 0);
    chk("holdrst_data", out_data0, 0);
    chk("holdrst_rdy", in_rdy0, 1);
    out_rdy = 1'b1;
    run_frame(tbl[4].s, 0, 0, -12, 0, -3, 0);

    // Random gapped frames against the arithmetic model.
    for (int f = 0; f < 40; f++) begin
      sum = 0;
      for (int i = 0; i < 4; i++) begin
        s[i] = int'($urandom_range(0, 255)) - 128;
        sum = sum + s[i];
      end
      e0 = ref_scale(sum, 0, t0);
      e2 = ref_scale(sum, 2, t2);
      run_frame(s, 2, int'($urandom_range(0, 3)), e0, t0, e2, t2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
